frame_buffer_writer: RTL and testbench



---
 rtl/frame_buffer_writer_if.sv | 39 +++
 rtl/frame_buffer_writer.sv | 125 ++++++++++++
 tb/tb_frame_buffer_writer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_writer_if.sv
// Pixel-stream and picture-RAM write-port bundle; the source drives master, the writer is slave.
// drop_count exists only when FBW_DROP_COUNT_EN is defined.
interface frame_buffer_writer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              enable;
  logic              pixel_valid;
  logic              pixel_sof;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_ready;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic              frame_done;
  logic              sync_error;
  logic [15:0]       frame_count;
`ifdef FBW_DROP_COUNT_EN
  logic [15:0]       drop_count;
`endif

  modport master (
    output enable, pixel_valid, pixel_sof, pixel_data,
    input  pixel_ready, ram_address, ram_data, ram_wren,
    input  frame_done, sync_error, frame_count
`ifdef FBW_DROP_COUNT_EN
    , input drop_count
`endif
  );

  modport slave (
    input  enable, pixel_valid, pixel_sof, pixel_data,
    output pixel_ready, ram_address, ram_data, ram_wren,
    output frame_done, sync_error, frame_count
`ifdef FBW_DROP_COUNT_EN
    , output drop_count
`endif
  );
endinterface

// File: rtl/frame_buffer_writer.sv
// Pixel stream to sequential picture-RAM writes, latency 1, 1 pixel/clock; optional FBW_DROP_COUNT_EN.
// Backpressure only while enable is high (active-low enable) or in reset; state is held meanwhile.
module frame_buffer_writer #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  frame_buffer_writer_if.slave  fb
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic {WAIT_SOF, WRITE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic              ram_wren_q, ram_wren_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_error_q, sync_error_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic              live_q, live_d;
`ifdef FBW_DROP_COUNT_EN
  logic [15:0]       drop_count_q, drop_count_d;
`endif

  logic              accept;
  logic              do_write;
  logic [ADDR_W-1:0] wr_addr;

  // Ready is gated by a flop cleared asynchronously so it drops the instant reset asserts.
  assign live_d         = 1'b1;
  assign fb.pixel_ready = live_q & ~fb.enable;
  assign accept         = fb.pixel_valid & fb.pixel_ready;

  always_comb begin
    state_d       = state_q;
    next_addr_d   = next_addr_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    frame_done_d  = 1'b0;
    sync_error_d  = 1'b0;
    frame_count_d = frame_count_q;
`ifdef FBW_DROP_COUNT_EN
    drop_count_d  = drop_count_q;
`endif
    do_write      = 1'b0;
    wr_addr       = next_addr_q;

    if (accept) begin
      if (fb.pixel_sof) begin
        do_write     = 1'b1;
        wr_addr      = '0;
        sync_error_d = (state_q == WRITE);
      end else if (state_q == WRITE) begin
        do_write = 1'b1;
      end
`ifdef FBW_DROP_COUNT_EN
      else if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
`endif
    end

    // Completing the last address always returns to WAIT_SOF, which also covers a 1-pixel frame.
    if (do_write) begin
      ram_wren_d    = 1'b1;
      ram_address_d = wr_addr;
      ram_data_d    = fb.pixel_data;
      if (wr_addr == LAST_ADDR) begin
        frame_done_d  = 1'b1;
        frame_count_d = frame_count_q + 16'd1;
        next_addr_d   = '0;
        state_d       = WAIT_SOF;
      end else begin
        next_addr_d = wr_addr + ADDR_ONE;
        state_d     = WRITE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= WAIT_SOF;
      next_addr_q   <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      sync_error_q  <= 1'b0;
      frame_count_q <= '0;
      live_q        <= 1'b0;
`ifdef FBW_DROP_COUNT_EN
      drop_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      next_addr_q   <= next_addr_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      frame_done_q  <= frame_done_d;
      sync_error_q  <= sync_error_d;
      frame_count_q <= frame_count_d;
      live_q        <= live_d;
`ifdef FBW_DROP_COUNT_EN
      drop_count_q  <= drop_count_d;
`endif
    end
  end

  assign fb.ram_address = ram_address_q;
  assign fb.ram_data    = ram_data_q;
  assign fb.ram_wren    = ram_wren_q;
  assign fb.frame_done  = frame_done_q;
  assign fb.sync_error  = sync_error_q;
  assign fb.frame_count = frame_count_q;
`ifdef FBW_DROP_COUNT_EN
  assign fb.drop_count  = drop_count_q;
`endif
endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: a 16-pixel instance for framing/pause/reset cases, a 1-pixel instance for count wrap.
module tb_frame_buffer_writer;
  logic clock = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;
  logic last_rdy;

  always #5 clock = ~clock;

  frame_buffer_writer_if #(.ADDR_W(4), .DATA_W(8)) fb ();
  frame_buffer_writer_if #(.ADDR_W(1), .DATA_W(8)) fb1 ();

  frame_buffer_writer #(.FRAME_PIXELS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .fb(fb)
  );
  frame_buffer_writer #(.FRAME_PIXELS(1), .ADDR_W(1), .DATA_W(8)) dut1 (
    .clock(clock), .reset_n(reset_n), .fb(fb1)
  );

  typedef struct packed {
    logic       en;
    logic       vld;
    logic       sof;
    logic [7:0] dat;
    logic       rdy;
    logic       wren;
    logic [3:0] addr;
    logic [7:0] data;
    logic       done;
    logic       sync;
    logic [15:0] fc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one beat on the falling edge, record ready, then sample just after the rising edge.
  task automatic beat(input logic en, input logic vld, input logic sof, input logic [7:0] dat);
    @(negedge clock);
    fb.enable      = en;
    fb.pixel_valid = vld;
    fb.pixel_sof   = sof;
    fb.pixel_data  = dat;
    #1;
    last_rdy = fb.pixel_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic wren, input logic [3:0] addr,
                        input logic done, input logic [15:0] fc);
    chk({tag, " wren"}, 32'(fb.ram_wren), 32'(wren));
    chk({tag, " addr"}, 32'(fb.ram_address), 32'(addr));
    chk({tag, " done"}, 32'(fb.frame_done), 32'(done));
    chk({tag, " fc"}, 32'(fb.frame_count), 32'(fc));
  endtask

  vec_t vecs[11];
  int   dones;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'h12, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h13, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h50, 1'b1, 1'b1, 4'd0, 8'h50, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h51, 1'b1, 1'b1, 4'd1, 8'h51, 1'b0, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0, 4'd1, 8'h51, 1'b0, 1'b0, 16'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h52, 1'b0, 1'b0, 4'd1, 8'h51, 1'b0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h52, 1'b1, 1'b1, 4'd2, 8'h52, 1'b0, 1'b0, 16'd0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 4'd0, 8'hAA, 1'b0, 1'b1, 16'd0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 4'd1, 8'h01, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 4'd1, 8'h01, 1'b0, 1'b0, 16'd0};

    reset_n         = 1'b0;
    fb.enable       = 1'b0;
    fb.pixel_valid  = 1'b0;
    fb.pixel_sof    = 1'b0;
    fb.pixel_data   = 8'h00;
    fb1.enable      = 1'b0;
    fb1.pixel_valid = 1'b0;
    fb1.pixel_sof   = 1'b0;
    fb1.pixel_data  = 8'h00;
    #3;
    chk("reset rdy", 32'(fb.pixel_ready), 32'd0);
    chk_wr("reset", 1'b0, 4'd0, 1'b0, 16'd0);
    chk("reset data", 32'(fb.ram_data), 32'd0);
    chk("reset sync", 32'(fb.sync_error), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post-reset rdy", 32'(fb.pixel_ready), 32'd1);

    // Table: pre-sof discards, idle gaps, pause, mid-frame resync.
    for (int i = 0; i < 11; i++) begin
      beat(vecs[i].en, vecs[i].vld, vecs[i].sof, vecs[i].dat);
      chk($sformatf("v%0d rdy", i), 32'(last_rdy), 32'(vecs[i].rdy));
      chk_wr($sformatf("v%0d", i), vecs[i].wren, vecs[i].addr, vecs[i].done, vecs[i].fc);
      chk($sformatf("v%0d data", i), 32'(fb.ram_data), 32'(vecs[i].data));
      chk($sformatf("v%0d sync", i), 32'(fb.sync_error), 32'(vecs[i].sync));
    end
`ifdef FBW_DROP_COUNT_EN
    chk("drop after table", 32'(fb.drop_count), 32'd2);
`endif

    // Finish the resynchronised frame back-to-back.
    for (int a = 2; a < 16; a++) begin
      beat(1'b0, 1'b1, 1'b0, 8'(a));
      chk_wr($sformatf("fin a%0d", a), 1'b1, 4'(a), (a == 15), (a == 15) ? 16'd1 : 16'd0);
      chk($sformatf("fin a%0d data", a), 32'(fb.ram_data), 32'(a));
    end
    beat(1'b0, 1'b1, 1'b0, 8'h77);
    chk_wr("after done discard", 1'b0, 4'd15, 1'b0, 16'd1);

    // Enable pause after address 7 with valid held high.
    beat(1'b0, 1'b1, 1'b1, 8'h00);
    chk_wr("pause f a0", 1'b1, 4'd0, 1'b0, 16'd1);
    for (int a = 1; a < 8; a++) begin
      beat(1'b0, 1'b1, 1'b0, 8'(a));
      chk_wr($sformatf("pause f a%0d", a), 1'b1, 4'(a), 1'b0, 16'd1);
    end
    for (int c = 0; c < 10; c++) begin
      beat(1'b1, 1'b1, 1'b0, 8'h08);
      chk($sformatf("pause c%0d rdy", c), 32'(last_rdy), 32'd0);
      chk($sformatf("pause c%0d wren", c), 32'(fb.ram_wren), 32'd0);
    end
    for (int a = 8; a < 16; a++) begin
      beat(1'b0, 1'b1, 1'b0, 8'(a));
      chk_wr($sformatf("resume a%0d", a), 1'b1, 4'(a), (a == 15), (a == 15) ? 16'd2 : 16'd1);
    end

    // Asynchronous reset between edges after address 9 is written.
    beat(1'b0, 1'b1, 1'b1, 8'h00);
    for (int a = 1; a < 10; a++) beat(1'b0, 1'b1, 1'b0, 8'(a));
    chk_wr("pre-reset a9", 1'b1, 4'd9, 1'b0, 16'd2);
    fb.pixel_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst rdy", 32'(fb.pixel_ready), 32'd0);
    chk_wr("arst", 1'b0, 4'd0, 1'b0, 16'd0);
    chk("arst data", 32'(fb.ram_data), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      beat(1'b0, 1'b1, 1'b0, 8'(8'h30 + c));
      chk_wr($sformatf("post-arst discard %0d", c), 1'b0, 4'd0, 1'b0, 16'd0);
    end
`ifdef FBW_DROP_COUNT_EN
    chk("drop after arst", 32'(fb.drop_count), 32'd5);
`endif
    beat(1'b0, 1'b1, 1'b1, 8'h5C);
    chk_wr("post-arst sof", 1'b1, 4'd0, 1'b0, 16'd0);
    chk("post-arst sof data", 32'(fb.ram_data), 32'h5C);
    beat(1'b0, 1'b0, 1'b0, 8'h00);

    // One-pixel frames: every sof completes a frame; 65536 of them wrap the count.
    dones = 0;
    for (int i = 0; i < 65536; i++) begin
      @(negedge clock);
      fb1.pixel_valid = 1'b1;
      fb1.pixel_sof   = 1'b1;
      fb1.pixel_data  = 8'(i);
      @(posedge clock);
      #1;
      if (fb1.frame_done) dones++;
      if (i == 0) begin
        chk("fp1 first fc", 32'(fb1.frame_count), 32'd1);
        chk("fp1 first wren", 32'(fb1.ram_wren), 32'd1);
        chk("fp1 first addr", 32'(fb1.ram_address), 32'd0);
      end
    end
    chk("fp1 done pulses", 32'(dones), 32'd65536);
    chk("fp1 fc wrapped", 32'(fb1.frame_count), 32'd0);
    chk("fp1 sync", 32'(fb1.sync_error), 32'd0);
    @(negedge clock);
    fb1.pixel_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("fp1 idle wren", 32'(fb1.ram_wren), 32'd0);
    chk("fp1 idle done", 32'(fb1.frame_done), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
